// File: rtl/uart_rx_word_if.sv
// uart_rx_word_if: serial line in and reassembled word/status out.
// master = receiver side (Rx in, word+strobes out); slave = line driver/consumer.
interface uart_rx_word_if;
    logic        Rx;
    logic [23:0] data_out;
    logic        valid;
    logic        frame_err;
    logic        timeout;

    modport master (
        input  Rx,
        output data_out,
        output valid,
        output frame_err,
        output timeout
    );

    modport slave (
        output Rx,
        input  data_out,
        input  valid,
        input  frame_err,
        input  timeout
    );
endinterface

// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 receiver packing three bytes (first -> [23:16]) into a word.
// Ports: clk, reset (sync, active-high), bus (master): Rx in; data_out, valid,
// frame_err, timeout out. Optional macro UART_RX_WORD_TIMEOUT_EN enables the
// partial-word idle timeout; without it timeout is tied to 0.
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int TIMEOUT_BITS = 40
) (
    input logic             clk,
    input logic             reset,
    uart_rx_word_if.master  bus
);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 16383) begin : g_bad_cpb
        $error("CLKS_PER_BIT out of range");
    end
    if (TIMEOUT_BITS < 1) begin : g_bad_tob
        $error("TIMEOUT_BITS must be positive");
    end

    localparam logic [13:0] BIT_LAST  = 14'(CLKS_PER_BIT - 1);
    localparam logic [13:0] HALF_LAST = 14'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q, rx_prev_q;
    logic        fall;
    logic [13:0] cnt_q, cnt_d;
    logic [2:0]  bidx_q, bidx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [7:0]  byte_sr_q, byte_sr_d;
    logic [15:0] word_acc_q, word_acc_d;
    logic [23:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        tout_q, tout_d;

`ifdef UART_RX_WORD_TIMEOUT_EN
    localparam logic [23:0] IDLE_LAST = 24'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
    logic [23:0] idle_q, idle_d;
`endif

    // Falling edge needs a fresh 1->0 transition; a line held low never retriggers.
    assign fall = rx_prev_q & ~rx_s_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bidx_q     <= '0;
            bcnt_q     <= '0;
            byte_sr_q  <= '0;
            word_acc_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            tout_q     <= 1'b0;
`ifdef UART_RX_WORD_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            rx_meta_q  <= bus.Rx;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bidx_q     <= bidx_d;
            bcnt_q     <= bcnt_d;
            byte_sr_q  <= byte_sr_d;
            word_acc_q <= word_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            tout_q     <= tout_d;
`ifdef UART_RX_WORD_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bidx_d     = bidx_q;
        bcnt_d     = bcnt_q;
        byte_sr_d  = byte_sr_q;
        word_acc_d = word_acc_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        tout_d     = 1'b0;
`ifdef UART_RX_WORD_TIMEOUT_EN
        idle_d     = idle_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = S_START;
                end
`ifdef UART_RX_WORD_TIMEOUT_EN
                if (fall || bcnt_q == 2'd0) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    idle_d     = '0;
                    bcnt_d     = '0;
                    word_acc_d = '0;
                    tout_d     = 1'b1;
                end else begin
                    idle_d = idle_q + 24'd1;
                end
`endif
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d  = '0;
                    bidx_d = '0;
                    // Line back high at mid-start means a glitch, not a frame.
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    byte_sr_d = {rx_s_q, byte_sr_q[7:1]};
                    if (bidx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rx_s_q) begin
                        ferr_d = 1'b1;
                        bcnt_d = '0;
                    end else if (bcnt_q == 2'd2) begin
                        data_d  = {word_acc_q, byte_sr_q};
                        valid_d = 1'b1;
                        bcnt_d  = '0;
                    end else begin
                        word_acc_d = {word_acc_q[7:0], byte_sr_q};
                        bcnt_d     = bcnt_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.data_out  = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
`ifdef UART_RX_WORD_TIMEOUT_EN
    assign bus.timeout   = tout_q;
`else
    assign bus.timeout   = 1'b0;
    logic unused_tout;
    assign unused_tout = tout_q;
`endif

endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: directed 8N1 frames into uart_rx_word, CLKS_PER_BIT=16.
// Strobes are counted on the falling clock edge; expected words are hand-computed.
module tb_uart_rx_word;

    localparam int CPB = 16;
    localparam int TOB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_rx_word_if bus ();

    uart_rx_word #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_tout = 0;
    int n_both = 0;
    logic [23:0] last_word = '0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.valid) begin
                n_valid   <= n_valid + 1;
                last_word <= bus.data_out;
            end
            if (bus.frame_err) n_ferr <= n_ferr + 1;
            if (bus.timeout) n_tout <= n_tout + 1;
            if ((bus.valid && bus.frame_err) || (bus.timeout && (bus.valid || bus.frame_err)))
                n_both <= n_both + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic v, input int n);
        bus.Rx = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(stop, CPB);
    endtask

    task automatic send_word(input logic [23:0] w);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    int v0, f0, t0;
    logic [7:0] rb;

    initial begin
        bus.Rx = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_data", 32'(bus.data_out), 32'h0);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_ferr", 32'(bus.frame_err), 32'h0);
        chk("rst_tout", 32'(bus.timeout), 32'h0);
        @(posedge clk);
        reset = 1'b0;
        drive(1'b1, 20);

        // Back-to-back bytes.
        v0 = n_valid; f0 = n_ferr;
        send_word(24'hA53C0F);
        drive(1'b1, 8);
        chk("b2b_nvalid", 32'(n_valid - v0), 32'd1);
        chk("b2b_word", 32'(last_word), 32'hA53C0F);
        chk("b2b_data", 32'(bus.data_out), 32'hA53C0F);
        chk("b2b_ferr", 32'(n_ferr - f0), 32'd0);

        // Transmitter-style word.
        v0 = n_valid;
        send_word(24'h123456);
        drive(1'b1, 8);
        chk("tx_nvalid", 32'(n_valid - v0), 32'd1);
        chk("tx_word", 32'(last_word), 32'h123456);

        // Short low glitch on idle line.
        v0 = n_valid; f0 = n_ferr;
        drive(1'b0, 4);
        drive(1'b1, 40);
        chk("gl_nvalid", 32'(n_valid - v0), 32'd0);
        chk("gl_ferr", 32'(n_ferr - f0), 32'd0);
        chk("gl_hold", 32'(bus.data_out), 32'h123456);

        // Bad stop bit drops the partial word.
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        chk("fe_ferr", 32'(n_ferr - f0), 32'd1);
        chk("fe_nvalid", 32'(n_valid - v0), 32'd0);
        drive(1'b1, 16);
        send_word(24'hAABBCC);
        drive(1'b1, 8);
        chk("fe_word", 32'(last_word), 32'hAABBCC);
        chk("fe_nvalid2", 32'(n_valid - v0), 32'd1);
        chk("fe_ferr2", 32'(n_ferr - f0), 32'd1);

        // Partial word then long idle.
        v0 = n_valid; t0 = n_tout;
        send_byte(8'h55, 1'b1);
        drive(1'b1, 64);
`ifdef UART_RX_WORD_TIMEOUT_EN
        chk("to_ntout", 32'(n_tout - t0), 32'd1);
`else
        chk("to_ntout", 32'(n_tout - t0), 32'd0);
`endif
        send_word(24'h010203);
        drive(1'b1, 8);
        chk("to_nvalid", 32'(n_valid - v0), 32'd1);
`ifdef UART_RX_WORD_TIMEOUT_EN
        chk("to_word", 32'(last_word), 32'h010203);
`else
        chk("to_word", 32'(last_word), 32'h550102);
`endif

        // Reset mid-frame during bit 4 of the second byte.
        send_byte(8'h77, 1'b1);
        rb = 8'h99;
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(rb[i], CPB);
        drive(rb[4], CPB / 2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mr_data", 32'(bus.data_out), 32'h0);
        chk("mr_valid", 32'(bus.valid), 32'h0);
        chk("mr_ferr", 32'(bus.frame_err), 32'h0);
        chk("mr_tout", 32'(bus.timeout), 32'h0);
        @(posedge clk);
        reset = 1'b0;
        v0 = n_valid;
        drive(1'b1, 32);
        send_word(24'hDEADBE);
        drive(1'b1, 8);
        chk("mr_nvalid", 32'(n_valid - v0), 32'd1);
        chk("mr_word", 32'(last_word), 32'hDEADBE);
        chk("excl", 32'(n_both), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
